seg_display_scheduler: RTL and testbench
========================================

Name: seg_display_scheduler

Overview:
Time-shares the single 4-digit seven-segment display path between up to NUM_SRC measurement sources (e.g. frequency, Vpp, timebase, trigger level). It selects sources round-robin and drives the counting binary-to-BCD converter through a start/done handshake. It latches the converted digits for the segment decoders and holds each result on screen for a fixed dwell time before rotating. It sits between the scope measurement logic and the seven-segment decode stage.

Parameters:
NUM_SRC, 4, number of requesting sources (2..8)
DWELL_CYCLES, 50000000, clock cycles each result stays on display (1 s at 50 MHz)
CONV_TIMEOUT, 20000, max cycles to wait for conv_done before abandoning a conversion

Ports:
clock  in  1  system clock; everything is on its rising edge
reset  in  1  synchronous, active-high reset
src_valid  in  NUM_SRC  bit i = source i has a value to show
src_value  in  14*NUM_SRC  source i value at bits [14i+13:14i], unsigned binary
src_ack  out  NUM_SRC  one-cycle pulse on bit i when source i's value is put on display
hold  in  1  level; 1 = keep refreshing the current source instead of rotating
conv_start  out  1  one-cycle start pulse to converter
conv_number  out  14  binary value to converter, stable from conv_start until next selection
conv_done  in  1  converter done level (stale-high until the converter sees start)
conv_digits  in  16  converter result {thousands,hundreds,tens,ones}, 4 bits each
disp_digits  out  16  latched BCD digits to segment decoders, same packing
disp_src  out  3  index of source currently displayed
disp_valid  out  1  1 once any result has been latched
conv_error  out  1  sticky; set on converter timeout, cleared only by reset

Behaviour:
- Reset values: disp_digits=0, disp_src=0, disp_valid=0, conv_start=0, conv_number=0, src_ack=0, conv_error=0. Round-robin pointer last=NUM_SRC-1, so the first search starts at source 0. State=IDLE.
- Reset asserted in any state aborts the operation that cycle. No ack is issued and the digits are not updated.
- FSM states: IDLE, START, WAIT, DWELL.
- IDLE: search src_valid from last+1 upward, wrapping modulo NUM_SRC.
  - If no source is valid: stay in IDLE; display outputs unchanged.
  - Otherwise: capture index sel and value; values >9999 clamp to 9999. Next state is START.
- START: conv_start=1 for exactly this cycle; conv_number = captured value. Next state is WAIT.
- WAIT:
  - conv_done is ignored in the first WAIT cycle (stale done from the previous conversion). It is accepted from the second WAIT cycle onward.
  - conv_done=1 accepted at cycle M: at M+1 disp_digits<=conv_digits (sampled at M), disp_src<=sel, disp_valid<=1, src_ack[sel]=1 for that cycle only, last<=sel. State becomes DWELL.
  - Timeout after CONV_TIMEOUT cycles in WAIT without done: conv_error<=1, last<=sel, no ack, display unchanged. Next state is IDLE.
- DWELL: counter runs DWELL_CYCLES cycles, including the entry cycle. At expiry:
  - If hold=1 and src_valid[sel]=1: go to START with sel and a freshly captured, clamped value (same-source refresh).
  - Otherwise go to IDLE (normal rotation).
- src_valid deasserting mid-conversion does not abort the conversion; the result is still shown and acked.
- A single valid source is reselected every rotation.
- Latency: valid seen in IDLE at cycle N gives conv_start at N+1. Earliest display update is N+4 (done at N+3).
- conv_digits is latched unchecked; BCD validity is the converter's responsibility.

Test Plan:
- Bench: DWELL_CYCLES=8, CONV_TIMEOUT=32, converter model asserts done 5 cycles after start. Reset, src_valid=0 for 20 cycles -> conv_start never pulses; all outputs remain at reset values.
- src_valid=4'b1111, values 1234/5/9999/42 -> conversions in order 0,1,2,3,0. disp_digits=16'h1234, 0005, 9999, 0042 with disp_src 0..3. Each src_ack single-cycle and aligned with its display update. Updates spaced 8 + conversion cycles apart.
- src_valid=4'b0101 -> only sources 0 and 2 are shown, alternating. src_value[2]=12000 -> conv_number=9999.
- hold=1 while source 1 is displayed; change its value 77 -> 78 -> source 1 reconverted each dwell and disp_digits becomes 0078. hold=0 -> next selection is source 2.
- Converter model holds done=1 stale from the prior run, then delays 40 cycles -> the stale done is not accepted. Timeout at 32 WAIT cycles sets conv_error=1, display unchanged, next source selected. conv_error stays 1 until reset.
- Reset pulsed during WAIT -> next cycle all outputs are at reset values and state is IDLE. The first selection after reset is source 0.

Source files
------------

// File: rtl/seg_display_scheduler.sv
// Round-robin scheduler that shares one binary-to-BCD converter and one 4-digit display
// among several measurement sources, holding each converted result for a dwell period.
module seg_display_scheduler #(
   parameter int NUM_SRC      = 4,
   parameter int DWELL_CYCLES = 50000000,
   parameter int CONV_TIMEOUT = 20000
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [NUM_SRC-1:0]      src_valid,
   input  logic [14*NUM_SRC-1:0]   src_value,
   output logic [NUM_SRC-1:0]      src_ack,
   input  logic                    hold,
   output logic                    conv_start,
   output logic [13:0]             conv_number,
   input  logic                    conv_done,
   input  logic [15:0]             conv_digits,
   output logic [15:0]             disp_digits,
   output logic [2:0]              disp_src,
   output logic                    disp_valid,
   output logic                    conv_error
);

   localparam int DW = $clog2(DWELL_CYCLES + 1);
   localparam int TW = $clog2(CONV_TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DWELL} state_t;

   state_t               r_state;
   logic [2:0]           r_last;
   logic [2:0]           r_sel;
   logic [13:0]          r_number;
   logic                 r_start;
   logic [NUM_SRC-1:0]   r_ack;
   logic [15:0]          r_digits;
   logic [2:0]           r_disp_src;
   logic                 r_vld;
   logic                 r_err;
   logic [DW-1:0]        r_dwell_cnt;
   logic [TW-1:0]        r_wait_cnt;

   logic                 w_found;
   logic [2:0]           w_next;
   logic [13:0]          w_next_val;
   logic [13:0]          w_sel_val;
   logic                 w_sel_valid;

   // The display only has four digits, so anything larger pins at 9999.
   function automatic logic [13:0] clamp_value(input logic [13:0] v);
      return (v > 14'd9999) ? 14'd9999 : v;
   endfunction

   // First valid source strictly after the last one served, wrapping around.
   always_comb begin
      w_found    = 1'b0;
      w_next     = '0;
      w_next_val = '0;
      for (int k = 1; k <= NUM_SRC; k++) begin
         for (int i = 0; i < NUM_SRC; i++) begin
            if (!w_found && src_valid[i] && (i == (int'(r_last) + k) % NUM_SRC)) begin
               w_found    = 1'b1;
               w_next     = 3'(i);
               w_next_val = src_value[i*14 +: 14];
            end
         end
      end
   end

   always_comb begin
      w_sel_val   = '0;
      w_sel_valid = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (3'(i) == r_sel) begin
            w_sel_val   = src_value[i*14 +: 14];
            w_sel_valid = src_valid[i];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_last      <= 3'(NUM_SRC - 1);
         r_sel       <= '0;
         r_number    <= '0;
         r_start     <= 1'b0;
         r_ack       <= '0;
         r_digits    <= '0;
         r_disp_src  <= '0;
         r_vld       <= 1'b0;
         r_err       <= 1'b0;
         r_dwell_cnt <= '0;
         r_wait_cnt  <= '0;
      end else begin
         r_start <= 1'b0;
         r_ack   <= '0;
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_sel    <= w_next;
                  r_number <= clamp_value(w_next_val);
                  r_start  <= 1'b1;
                  r_state  <= S_START;
               end
            end
            S_START: begin
               r_wait_cnt <= '0;
               r_state    <= S_WAIT;
            end
            S_WAIT: begin
               // done seen in the first WAIT cycle is left over from the previous conversion
               if (conv_done && (r_wait_cnt != '0)) begin
                  r_digits    <= conv_digits;
                  r_disp_src  <= r_sel;
                  r_vld       <= 1'b1;
                  r_ack       <= NUM_SRC'(1) << r_sel;
                  r_last      <= r_sel;
                  r_dwell_cnt <= '0;
                  r_state     <= S_DWELL;
               end else if (r_wait_cnt == TW'(CONV_TIMEOUT - 1)) begin
                  r_err   <= 1'b1;
                  r_last  <= r_sel;
                  r_state <= S_IDLE;
               end else begin
                  r_wait_cnt <= r_wait_cnt + TW'(1);
               end
            end
            S_DWELL: begin
               if (r_dwell_cnt == DW'(DWELL_CYCLES - 1)) begin
                  if (hold && w_sel_valid) begin
                     r_number <= clamp_value(w_sel_val);
                     r_start  <= 1'b1;
                     r_state  <= S_START;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end else begin
                  r_dwell_cnt <= r_dwell_cnt + DW'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign src_ack     = r_ack;
   assign conv_start  = r_start;
   assign conv_number = r_number;
   assign disp_digits = r_digits;
   assign disp_src    = r_disp_src;
   assign disp_valid  = r_vld;
   assign conv_error  = r_err;

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Bench for seg_display_scheduler: converter model plus a transaction-level predictor
// of source selection, clamping, BCD display contents and event spacing.
module tb_seg_display_scheduler;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int TO = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [N-1:0]  src_valid = '0;
   logic [14*N-1:0] src_value = '0;
   logic [N-1:0]  src_ack;
   logic          hold = 1'b0;
   logic          conv_start;
   logic [13:0]   conv_number;
   logic          conv_done;
   logic [15:0]   conv_digits;
   logic [15:0]   disp_digits;
   logic [2:0]    disp_src;
   logic          disp_valid;
   logic          conv_error;

   int n_run  = 0;
   int n_fail = 0;
   int cyc    = 0;

   // predictor state
   int          m_val[N];
   int          m_last = N - 1;
   logic [15:0] exp_digits = '0;
   logic [2:0]  exp_src = '0;
   logic        exp_vld = 1'b0;
   logic        exp_err = 1'b0;
   int          last_upd = 0;

   seg_display_scheduler #(.NUM_SRC(N), .DWELL_CYCLES(DW), .CONV_TIMEOUT(TO)) dut (
      .clock(clk), .reset(rst), .src_valid(src_valid), .src_value(src_value),
      .src_ack(src_ack), .hold(hold), .conv_start(conv_start), .conv_number(conv_number),
      .conv_done(conv_done), .conv_digits(conv_digits), .disp_digits(disp_digits),
      .disp_src(disp_src), .disp_valid(disp_valid), .conv_error(conv_error)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [15:0] bcd(input int v);
      logic [15:0] r;
      r[15:12] = 4'(v / 1000);
      r[11:8]  = 4'((v / 100) % 10);
      r[7:4]   = 4'((v / 10) % 10);
      r[3:0]   = 4'(v % 10);
      return r;
   endfunction

   function automatic int clampv(input int v);
      return (v > 9999) ? 9999 : v;
   endfunction

   function automatic int exp_next(input int last, input logic [N-1:0] mask);
      for (int k = 1; k <= N; k++)
         if (mask[(last + k) % N]) return (last + k) % N;
      return -1;
   endfunction

   // converter: done goes high 'delay' cycles after start and stays high until the next start;
   // with stale_lag it is still high in the first cycle after start
   int          age = 0;
   int          delay = 5;
   bit          stale_lag = 1'b0;
   logic [13:0] cnum = '0;
   always @(posedge clk) begin
      if (rst) age <= 0;
      else if (conv_start) begin age <= 1; cnum <= conv_number; end
      else if (age != 0 && age < 1000) age <= age + 1;
   end
   assign conv_done   = ((age == 1) && stale_lag) || ((age != 0) && (age >= delay));
   assign conv_digits = bcd(int'(cnum));

   task automatic set_val(input int i, input int v);
      m_val[i] = v;
      src_value[i*14 +: 14] = 14'(v);
   endtask

   task automatic rand_vals();
      for (int i = 0; i < N; i++) set_val(i, int'($urandom_range(0, 16383)));
   endtask

   task automatic reset_model();
      m_last = N - 1; exp_digits = '0; exp_src = '0; exp_vld = 1'b0; exp_err = 1'b0;
   endtask

   // one conversion of source sel with value val; gap = expected cycles from previous update to start (-1 = skip)
   task automatic do_conv(input int sel, input int val, input int gap);
      int cs, cu, extra;
      bit got;
      logic [15:0] pre_dig;
      logic [2:0] pre_src;
      logic pre_vld;
      got = 0; cs = 0; cu = 0; extra = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (conv_start === 1'b1) begin got = 1; cs = cyc; break; end
      end
      n_run++;
      if (!got) begin
         n_fail++; $display("FAIL start_seen: no conv_start in 100 cycles, expected src %0d", sel);
         return;
      end
      n_run++;
      if (conv_number !== 14'(clampv(val))) begin
         n_fail++; $display("FAIL conv_number: got %0d expected %0d (src %0d)", conv_number, clampv(val), sel);
      end
      if (gap >= 0) begin
         n_run++;
         if (cs - last_upd != gap) begin
            n_fail++; $display("FAIL start_spacing: got %0d expected %0d", cs - last_upd, gap);
         end
      end
      got = 0; pre_dig = disp_digits; pre_src = disp_src; pre_vld = disp_valid;
      for (int i = 0; i < 60; i++) begin
         pre_dig = disp_digits; pre_src = disp_src; pre_vld = disp_valid;
         @(negedge clk);
         if (conv_start === 1'b1) extra++;
         if (src_ack !== '0) begin got = 1; cu = cyc; break; end
      end
      n_run++;
      if (extra != 0) begin n_fail++; $display("FAIL start_single: got %0d extra start cycles expected 0", extra); end
      n_run++;
      if (!got) begin
         n_fail++; $display("FAIL ack_seen: no src_ack in 60 cycles, expected src %0d", sel);
         return;
      end
      n_run++;
      if (pre_dig !== exp_digits || pre_src !== exp_src || pre_vld !== exp_vld) begin
         n_fail++; $display("FAIL display_before_ack: got %h/%0d/%0d expected %h/%0d/%0d",
                            pre_dig, pre_src, pre_vld, exp_digits, exp_src, exp_vld);
      end
      exp_digits = bcd(clampv(val)); exp_src = 3'(sel); exp_vld = 1'b1;
      n_run++;
      if (src_ack !== N'(1 << sel)) begin n_fail++; $display("FAIL ack_bits: got %b expected %b", src_ack, N'(1 << sel)); end
      n_run++;
      if (disp_src !== exp_src) begin n_fail++; $display("FAIL disp_src: got %0d expected %0d", disp_src, exp_src); end
      n_run++;
      if (disp_digits !== exp_digits) begin n_fail++; $display("FAIL disp_digits: got %h expected %h", disp_digits, exp_digits); end
      n_run++;
      if (disp_valid !== 1'b1) begin n_fail++; $display("FAIL disp_valid: got %b expected 1", disp_valid); end
      n_run++;
      if (conv_error !== exp_err) begin n_fail++; $display("FAIL conv_error: got %b expected %b", conv_error, exp_err); end
      n_run++;
      if (cu - cs != 6) begin n_fail++; $display("FAIL conv_latency: got %0d expected 6", cu - cs); end
      m_last = sel; last_upd = cu;
      @(negedge clk);
      n_run++;
      if (src_ack !== '0) begin n_fail++; $display("FAIL ack_single: got %b expected 0", src_ack); end
   endtask

   task automatic test_reset();
      int starts, acks;
      starts = 0; acks = 0;
      @(negedge clk); rst = 1'b1; src_valid = '0; hold = 1'b0; rand_vals();
      repeat (3) @(negedge clk);
      rst = 1'b0; reset_model();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (conv_start === 1'b1) starts++;
         if (src_ack !== '0) acks++;
      end
      n_run++; if (starts != 0) begin n_fail++; $display("FAIL idle_starts: got %0d expected 0", starts); end
      n_run++; if (acks != 0) begin n_fail++; $display("FAIL idle_acks: got %0d expected 0", acks); end
      n_run++; if (disp_digits !== 16'h0) begin n_fail++; $display("FAIL rst_digits: got %h expected 0", disp_digits); end
      n_run++; if (disp_src !== 3'd0) begin n_fail++; $display("FAIL rst_src: got %0d expected 0", disp_src); end
      n_run++; if (disp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", disp_valid); end
      n_run++; if (conv_error !== 1'b0) begin n_fail++; $display("FAIL rst_error: got %b expected 0", conv_error); end
      n_run++; if (conv_number !== 14'd0) begin n_fail++; $display("FAIL rst_number: got %0d expected 0", conv_number); end
   endtask

   task automatic test_round_robin();
      int sel;
      set_val(0, 1234); set_val(1, 5); set_val(2, 9999); set_val(3, 42);
      src_valid = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         sel = exp_next(m_last, src_valid);
         do_conv(sel, m_val[sel], (k == 0) ? -1 : 9);
      end
      for (int k = 0; k < 5; k++) begin
         rand_vals();
         sel = exp_next(m_last, src_valid);
         do_conv(sel, m_val[sel], 9);
      end
   endtask

   task automatic test_mask();
      int sel;
      src_valid = 4'b0101; set_val(0, 321); set_val(2, 12000);
      for (int k = 0; k < 4; k++) begin
         sel = exp_next(m_last, src_valid);
         do_conv(sel, m_val[sel], 9);
      end
      src_valid = 4'b0010; set_val(1, 8765);
      for (int k = 0; k < 2; k++) do_conv(exp_next(m_last, src_valid), m_val[1], 9);
      for (int k = 0; k < 8; k++) begin
         src_valid = N'($urandom_range(1, 15));
         rand_vals();
         sel = exp_next(m_last, src_valid);
         do_conv(sel, m_val[sel], 9);
      end
   endtask

   task automatic test_hold();
      int sel;
      bit seen1;
      seen1 = 0;
      src_valid = 4'b1111; rand_vals(); set_val(1, 77);
      for (int t = 0; t < 5 && !seen1; t++) begin
         sel = exp_next(m_last, src_valid);
         do_conv(sel, m_val[sel], 9);
         if (sel == 1) seen1 = 1;
      end
      hold = 1'b1; set_val(1, 78);
      do_conv(1, 78, 8);
      n_run++; if (disp_digits !== 16'h0078) begin n_fail++; $display("FAIL hold_digits: got %h expected 0078", disp_digits); end
      set_val(1, 79);
      do_conv(1, 79, 8);
      hold = 1'b0;
      do_conv(exp_next(m_last, src_valid), m_val[2], 9);
      hold = 1'b1; src_valid = 4'b1011;
      sel = exp_next(m_last, src_valid);
      do_conv(sel, m_val[sel], 9);
      hold = 1'b0; src_valid = 4'b1111;
   endtask

   task automatic test_timeout();
      int sel, cs, err_cyc, acks;
      bit got, seen;
      got = 0; seen = 0; cs = 0; err_cyc = 0; acks = 0;
      rand_vals(); stale_lag = 1'b1; delay = 40;
      sel = exp_next(m_last, src_valid);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (conv_start === 1'b1) begin got = 1; cs = cyc; break; end
      end
      n_run++;
      if (!got) begin n_fail++; $display("FAIL to_start_seen: no conv_start in 100 cycles"); end
      n_run++;
      if (conv_number !== 14'(clampv(m_val[sel]))) begin
         n_fail++; $display("FAIL to_number: got %0d expected %0d", conv_number, clampv(m_val[sel]));
      end
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (src_ack !== '0) acks++;
         if (conv_error === 1'b1) begin seen = 1; err_cyc = cyc; break; end
      end
      stale_lag = 1'b0; delay = 5;
      n_run++; if (!seen) begin n_fail++; $display("FAIL to_error_set: got 0 expected 1 within 60 cycles"); end
      n_run++; if (err_cyc - cs != TO + 1) begin n_fail++; $display("FAIL to_timing: got %0d expected %0d", err_cyc - cs, TO + 1); end
      n_run++; if (acks != 0) begin n_fail++; $display("FAIL to_no_ack: got %0d acks expected 0", acks); end
      n_run++;
      if (disp_digits !== exp_digits || disp_src !== exp_src || disp_valid !== exp_vld) begin
         n_fail++; $display("FAIL to_display_kept: got %h/%0d expected %h/%0d", disp_digits, disp_src, exp_digits, exp_src);
      end
      m_last = sel; exp_err = 1'b1; last_upd = err_cyc;
      sel = exp_next(m_last, src_valid);
      do_conv(sel, m_val[sel], 1);
      sel = exp_next(m_last, src_valid);
      do_conv(sel, m_val[sel], 9);
   endtask

   task automatic test_reset_in_wait();
      bit got;
      got = 0;
      src_valid = 4'b1111; rand_vals();
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (conv_start === 1'b1) begin got = 1; break; end
      end
      n_run++; if (!got) begin n_fail++; $display("FAIL rw_start_seen: no conv_start in 100 cycles"); end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_run++; if (disp_digits !== 16'h0) begin n_fail++; $display("FAIL rw_digits: got %h expected 0", disp_digits); end
      n_run++; if (disp_src !== 3'd0) begin n_fail++; $display("FAIL rw_src: got %0d expected 0", disp_src); end
      n_run++; if (disp_valid !== 1'b0) begin n_fail++; $display("FAIL rw_valid: got %b expected 0", disp_valid); end
      n_run++; if (conv_error !== 1'b0) begin n_fail++; $display("FAIL rw_error: got %b expected 0", conv_error); end
      n_run++; if (src_ack !== '0) begin n_fail++; $display("FAIL rw_ack: got %b expected 0", src_ack); end
      n_run++; if (conv_start !== 1'b0 || conv_number !== 14'd0) begin
         n_fail++; $display("FAIL rw_conv: got start %b number %0d expected 0/0", conv_start, conv_number);
      end
      rst = 1'b0; reset_model();
      do_conv(exp_next(m_last, src_valid), m_val[0], -1);
      n_run++; if (disp_src !== 3'd0) begin n_fail++; $display("FAIL rw_first_src: got %0d expected 0", disp_src); end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_mask();
      test_hold();
      test_timeout();
      test_reset_in_wait();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
